// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: register offsets, STATUS bit positions, FSM encodings.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_PARITY_ERR = 5;

    localparam logic [15:0] BAUD_MIN = 16'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    function automatic logic [15:0] baud_clamp(input logic [15:0] v);
        return (v < BAUD_MIN) ? BAUD_MIN : v;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with show-ahead output; a push is accepted when full only if a pop happens in the same cycle.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push_s, do_pop_s;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_CNT);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign dout      = mem_q[rd_q];

    // Storage array
    always_ff @(posedge aclk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + AW'(1);
            if (do_pop_s)  rd_q <= rd_q + AW'(1);
            if (do_push_s && !do_pop_s)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop_s && !do_push_s) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_sram_core.sv
// UART core on the bridge SRAM port: TX/RX FIFOs, baud divider, level RX interrupt.
// Define UART_PARITY_EN for 8E1 framing with a sticky parity_err flag; default is 8N1.
module uart_sram_core
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ram_ren,
    input  logic [31:0] ram_raddr,
    output logic [31:0] ram_rdata,
    input  logic [3:0]  ram_wen,
    input  logic [31:0] ram_waddr,
    input  logic [31:0] ram_wdata,
    output logic        irq_rx,
    output logic        tx_pin,
    input  logic        rx_pin
);
    logic [1:0]  rd_sel_s, wr_sel_s;
    logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, stat_rd_s;
    logic [7:0]  tx_dout_s, rx_dout_s, status_s;
    logic        ctrl_q, irq_q, ovr_q, ovr_d;
    logic [15:0] baud_q, baud_wr_s;
    logic [31:0] rdata_q, rdata_d;
    tx_state_e   tx_state_q, tx_state_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic        tx_q, tx_d, tx_tick_s, rx_tick_s, rx_ok_s, stop_ok_s;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        unused_s;

    assign unused_s  = ^{ram_raddr[31:4], ram_raddr[1:0], ram_waddr[31:4], ram_waddr[1:0],
                         ram_wdata[31:16], ram_wen[3:2]};
    assign rd_sel_s  = ram_raddr[3:2];
    assign wr_sel_s  = ram_waddr[3:2];
    assign tx_push_s = (wr_sel_s == REG_DATA) & ram_wen[0];
    assign rx_pop_s  = ram_ren & (rd_sel_s == REG_DATA) & ~rx_empty_s;
    assign stat_rd_s = ram_ren & (rd_sel_s == REG_STATUS);
    assign baud_wr_s = {ram_wen[1] ? ram_wdata[15:8] : baud_q[15:8],
                        ram_wen[0] ? ram_wdata[7:0]  : baud_q[7:0]};
    assign tx_tick_s = (tx_cnt_q == 16'd0);
    assign rx_tick_s = (rx_cnt_q == 16'd0);
    assign stop_ok_s = (rx_state_q == RX_STOP) & rx_tick_s & rx_s2_q;
    assign ram_rdata = rdata_q;
    assign irq_rx    = irq_q;
    assign tx_pin    = tx_q;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(tx_push_s), .pop(tx_pop_s),
        .din(ram_wdata[7:0]), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s));

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(rx_push_s), .pop(rx_pop_s),
        .din(rx_sh_q), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s));

`ifdef UART_PARITY_EN
    logic tx_par_q, rx_pbad_q, perr_q;

    // Parity capture for TX, parity check result for RX, sticky parity error
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_par_q  <= 1'b0;
            rx_pbad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            if (tx_pop_s) tx_par_q <= ^tx_dout_s;
            if (rx_state_q == RX_PARITY && rx_tick_s) rx_pbad_q <= rx_s2_q ^ (^rx_sh_q);
            perr_q <= (perr_q & ~stat_rd_s) | (stop_ok_s & rx_pbad_q);
        end
    end
    assign rx_ok_s = ~rx_pbad_q;
`else
    assign rx_ok_s = 1'b1;
`endif

    assign rx_push_s = stop_ok_s & rx_ok_s;

    // STATUS vector, read mux and sticky overrun next state
    always_comb begin
        status_s                = 8'd0;
        status_s[ST_RX_VALID]   = ~rx_empty_s;
        status_s[ST_TX_FULL]    = tx_full_s;
        status_s[ST_TX_EMPTY]   = tx_empty_s;
        status_s[ST_RX_OVERRUN] = ovr_q;
        status_s[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
`ifdef UART_PARITY_EN
        status_s[ST_PARITY_ERR] = perr_q;
`endif
        ovr_d   = (ovr_q & ~stat_rd_s) | (rx_push_s & rx_full_s & ~rx_pop_s);
        rdata_d = rdata_q;
        if (ram_ren) begin
            case (rd_sel_s)
                REG_DATA:   rdata_d = rx_empty_s ? 32'd0 : {24'd0, rx_dout_s};
                REG_STATUS: rdata_d = {24'd0, status_s};
                REG_CTRL:   rdata_d = {31'd0, ctrl_q};
                REG_BAUD:   rdata_d = {16'd0, baud_q};
                default:    rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Host registers, read data, interrupt and overrun flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= 32'd0;
            ctrl_q  <= 1'b0;
            baud_q  <= DIV_RESET;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            irq_q   <= ctrl_q & ~rx_empty_s;
            ovr_q   <= ovr_d;
            if (wr_sel_s == REG_CTRL && ram_wen[0]) ctrl_q <= ram_wdata[0];
            if (wr_sel_s == REG_BAUD && ram_wen[1:0] != 2'b00) baud_q <= baud_clamp(baud_wr_s);
        end
    end

    // TX next state; the divider reloads at every bit boundary so BAUD changes land there
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_pop_s   = 1'b0;
        if (tx_state_q != TX_IDLE && !tx_tick_s) tx_cnt_d = tx_cnt_q - 16'd1;
        else                                     tx_cnt_d = baud_q - 16'd1;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = tx_empty_s;
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_sh_d    = tx_dout_s;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_sh_q[0];
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_tick_s && tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_state_d = TX_PARITY;
                    tx_d       = tx_par_q;
`else
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
`endif
                end else if (tx_tick_s) begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_d     = tx_sh_q[1];
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_tick_s) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_state_d = TX_PARITY;
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit so consecutive bytes have no gap
                if (tx_tick_s && !tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_sh_d    = tx_dout_s;
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                end else if (tx_tick_s) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // RX next state: start bit checked at mid-bit, then one sample per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        if (rx_state_q != RX_IDLE && !rx_tick_s) rx_cnt_d = rx_cnt_q - 16'd1;
        else                                     rx_cnt_d = baud_q - 16'd1;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = (baud_q >> 1) - 16'd1;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_tick_s) begin
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_PARITY : RX_DATA;
`else
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
`endif
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_PARITY: rx_state_d = rx_tick_s ? RX_STOP : RX_PARITY;
            RX_STOP:   rx_state_d = !rx_tick_s ? RX_STOP : (rx_s2_q ? RX_IDLE : RX_BREAK);
            RX_BREAK:  rx_state_d = rx_s2_q ? RX_IDLE : RX_BREAK;
            default:   rx_state_d = RX_IDLE;
        endcase
    end

    // FSM state, serial shift registers, line synchronizer
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_sh_q    <= 8'd0;
            tx_bit_q   <= 3'd0;
            tx_q       <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_sh_q    <= 8'd0;
            rx_bit_q   <= 3'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_s1_q    <= rx_pin;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
        end
    end

endmodule

// File: tb/tb_uart_sram_core.sv
// Directed bench for uart_sram_core (default 8N1 build).
module tb_uart_sram_core;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ram_ren = 1'b0;
    logic [31:0] ram_raddr = 32'd0;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_wen = 4'd0;
    logic [31:0] ram_waddr = 32'd0;
    logic [31:0] ram_wdata = 32'd0;
    logic        irq_rx, tx_pin, rx_pin;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        tx_prev = 1'b1;
    int          fall_cnt = 0;
    int          n_err = 0;
    int          n_chk = 0;

    assign rx_pin = loop_en ? tx_pin : rx_drv;

    always #5 aclk = ~aclk;

    // Counts start bits on tx_pin (one falling edge per 0xFF frame)
    always @(negedge aclk) begin
        if (tx_prev && !tx_pin) fall_cnt <= fall_cnt + 1;
        tx_prev <= tx_pin;
    end

    uart_sram_core #(.FIFO_DEPTH(16), .DIV_RESET(16'd434)) dut (
        .aclk(aclk), .aresetn(aresetn), .ram_ren(ram_ren), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .irq_rx(irq_rx), .tx_pin(tx_pin), .rx_pin(rx_pin));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        ram_waddr = {28'd0, a, 2'b00};
        ram_wdata = d;
        ram_wen   = be;
        tick();
        ram_wen   = 4'd0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        ram_raddr = {28'd0, a, 2'b00};
        ram_ren   = 1'b1;
        tick();
        ram_ren   = 1'b0;
        d         = ram_rdata;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (4) tick();
        end
        rx_drv = stop;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) tick();
        n_chk++; if (tx_pin !== 1'b1) begin n_err++; $display("FAIL rst_tx_pin got %b want 1", tx_pin); end
        n_chk++; if (irq_rx !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq_rx); end
        n_chk++; if (ram_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", ram_rdata); end
        aresetn = 1'b1;
        tick();
        reg_read(2'd0, d);
        n_chk++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_data got %h want 0", d); end
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h04) begin n_err++; $display("FAIL rst_status got %h want 04", d); end
        reg_read(2'd2, d);
        n_chk++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_ctrl got %h want 0", d); end
        reg_read(2'd3, d);
        n_chk++; if (d !== 32'd434) begin n_err++; $display("FAIL rst_baud got %0d want 434", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        reg_write(2'd3, 32'h0000_FF04, 4'b0001);
        reg_read(2'd3, d);
        n_chk++; if (d !== 32'h0104) begin n_err++; $display("FAIL baud_lane got %h want 0104", d); end
        reg_write(2'd3, 32'd2, 4'b0011);
        reg_read(2'd3, d);
        n_chk++; if (d !== 32'd4) begin n_err++; $display("FAIL baud_clamp got %0d want 4", d); end
        ram_waddr = 32'h8; ram_wdata = 32'd1; ram_wen = 4'b0001;
        ram_raddr = 32'h8; ram_ren = 1'b1;
        tick();
        ram_wen = 4'd0; ram_ren = 1'b0;
        n_chk++; if (ram_rdata !== 32'd0) begin n_err++; $display("FAIL ctrl_rw_old got %h want 0", ram_rdata); end
        reg_read(2'd2, d);
        n_chk++; if (d !== 32'd1) begin n_err++; $display("FAIL ctrl_new got %h want 1", d); end
        reg_write(2'd2, 32'd0, 4'b0001);
    endtask

    task automatic test_tx_frame();
        logic [7:0]  b;
        logic        e;
        logic [31:0] d;
        b = 8'hA5;
        reg_write(2'd0, {24'd0, b}, 4'b0001);
        tick();
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       e = 1'b0;
            else if (k < 36) e = b[(k - 4) / 4];
            else             e = 1'b1;
            n_chk++; if (tx_pin !== e) begin n_err++; $display("FAIL tx_bit k=%0d got %b want %b", k, tx_pin, e); end
            if (k == 10) begin
                ram_raddr = 32'h4; ram_ren = 1'b1;
            end else if (k == 11) begin
                ram_ren = 1'b0;
                n_chk++; if (ram_rdata !== 32'h14) begin n_err++; $display("FAIL tx_busy_status got %h want 14", ram_rdata); end
            end
            tick();
        end
        n_chk++; if (tx_pin !== 1'b1) begin n_err++; $display("FAIL tx_idle got %b want 1", tx_pin); end
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h04) begin n_err++; $display("FAIL tx_done_status got %h want 04", d); end
    endtask

    task automatic test_loopback_irq();
        logic [31:0] d;
        int t;
        loop_en = 1'b1;
        reg_write(2'd2, 32'd1, 4'b0001);
        reg_write(2'd0, 32'h3C, 4'b0001);
        t = 0;
        while (irq_rx !== 1'b1 && t < 200) begin tick(); t++; end
        n_chk++; if (irq_rx !== 1'b1) begin n_err++; $display("FAIL lb_irq_timeout got %b want 1", irq_rx); end
        repeat (10) tick();
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h05) begin n_err++; $display("FAIL lb_status got %h want 05", d); end
        reg_read(2'd0, d);
        n_chk++; if (d !== 32'h3C) begin n_err++; $display("FAIL lb_data got %h want 3c", d); end
        n_chk++; if (irq_rx !== 1'b1) begin n_err++; $display("FAIL lb_irq_hold got %b want 1", irq_rx); end
        tick();
        n_chk++; if (irq_rx !== 1'b0) begin n_err++; $display("FAIL lb_irq_drop got %b want 0", irq_rx); end
        reg_read(2'd0, d);
        n_chk++; if (d !== 32'd0) begin n_err++; $display("FAIL lb_empty_read got %h want 0", d); end
        loop_en = 1'b0;
        reg_write(2'd2, 32'd0, 4'b0001);
    endtask

    task automatic test_glitch_framing();
        logic [31:0] d;
        rx_drv = 1'b0;
        tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h04) begin n_err++; $display("FAIL glitch_status got %h want 04", d); end
        rx_frame(8'h55, 1'b0);
        repeat (10) tick();
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h04) begin n_err++; $display("FAIL framing_status got %h want 04", d); end
        rx_frame(8'h81, 1'b1);
        reg_read(2'd0, d);
        n_chk++; if (d !== 32'h81) begin n_err++; $display("FAIL rx_recover got %h want 81", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        for (int b = 0; b < 17; b++) rx_frame(8'(b), 1'b1);
        repeat (4) tick();
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h0D) begin n_err++; $display("FAIL ovr_status got %h want 0d", d); end
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h05) begin n_err++; $display("FAIL ovr_cleared got %h want 05", d); end
        for (int i = 0; i < 16; i++) begin
            reg_read(2'd0, d);
            n_chk++; if (d !== 32'(i)) begin n_err++; $display("FAIL ovr_data i=%0d got %h want %h", i, d, i); end
        end
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h04) begin n_err++; $display("FAIL ovr_drained got %h want 04", d); end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        int base, t;
        reg_write(2'd3, 32'd434, 4'b0011);
        base = fall_cnt;
        for (int i = 0; i < 17; i++) reg_write(2'd0, 32'hFF, 4'b0001);
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h12) begin n_err++; $display("FAIL txf_full got %h want 12", d); end
        reg_write(2'd0, 32'hFF, 4'b0001);
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h12) begin n_err++; $display("FAIL txf_still_full got %h want 12", d); end
        reg_write(2'd3, 32'd4, 4'b0011);
        t = 0;
        while ((fall_cnt - base) < 17 && t < 3000) begin tick(); t++; end
        repeat (80) tick();
        n_chk++; if ((fall_cnt - base) !== 17) begin n_err++; $display("FAIL txf_frames got %0d want 17", fall_cnt - base); end
        reg_read(2'd1, d);
        n_chk++; if (d !== 32'h04) begin n_err++; $display("FAIL txf_done got %h want 04", d); end
    endtask

    task automatic test_reset_midframe();
        reg_write(2'd0, 32'h00, 4'b0001);
        repeat (3) tick();
        n_chk++; if (tx_pin !== 1'b0) begin n_err++; $display("FAIL mid_start got %b want 0", tx_pin); end
        #2 aresetn = 1'b0;
        #1;
        n_chk++; if (tx_pin !== 1'b1) begin n_err++; $display("FAIL mid_reset_tx got %b want 1", tx_pin); end
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_regs();
        test_tx_frame();
        test_loopback_irq();
        test_glitch_framing();
        test_overrun();
        test_tx_full();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_sram_core.md
Name: uart_sram_core

Overview:
- UART peripheral core on the SRAM-like port driven by soc_axi_sram_bridge.
- Sits inside the UART wrapper, downstream of the bridge: bridge ram_* signals in, tx_pin/rx_pin/irq_rx out.
- Provides TX and RX byte FIFOs, a programmable baud divider, 8N1 framing and a level RX interrupt.

Parameters:
- FIFO_DEPTH, 16, entries per TX/RX FIFO; power of two, >=2.
- DIV_RESET, 16'd434, baud divider reset value in aclk cycles per bit (50 MHz / 115200).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- ram_ren  in  1  read strobe
- ram_raddr  in  32  read byte address; only [3:2] decoded
- ram_rdata  out  32  read data, registered
- ram_wen  in  4  per-byte write enables
- ram_waddr  in  32  write byte address; only [3:2] decoded
- ram_wdata  in  32  write data
- irq_rx  out  1  RX interrupt, level
- tx_pin  out  1  serial out, idle high
- rx_pin  in  1  serial in, asynchronous

Behaviour:
- Reset: ram_rdata=0, irq_rx=0, tx_pin=1, FIFOs empty, CTRL=0, BAUD=DIV_RESET, sticky flags=0, both FSMs IDLE.
- Register map by addr[3:2]:
  - 0 DATA: write pushes wdata[7:0] to TX FIFO when wen[0]. Read returns {24'b0, RX head} and pops.
  - 1 STATUS (read-only): bit0 rx_valid, bit1 tx_full, bit2 tx_empty, bit3 rx_overrun (sticky), bit4 tx_busy. Read clears bit3.
  - 2 CTRL: bit0 rx_irq_en; byte-lane writes.
  - 3 BAUD: [15:0] divider; wen[1:0] lanes; written values <4 are clamped to 4.
- Read latency:
  - ram_rdata updates on the edge after ram_ren=1 and holds until the next ren.
  - Pop and sticky-clear happen on that same edge.
  - raddr must be stable while ren=1.
- Write is single-cycle, no backpressure.
  - Push to a full TX FIFO is dropped.
  - Read of DATA with RX empty returns 0 and does not pop.
- Simultaneous read and write in one cycle are both honoured.
  - Write to CTRL/BAUD plus read of the same register returns the old value.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state lasts BAUD cycles via a 16-bit down-counter.
  - IDLE pops the TX FIFO when non-empty; the next cycle drives the start bit.
  - Back-to-back bytes have no idle gap.
  - tx_busy = state!=IDLE.
- RX path:
  - rx_pin passes a 2-flop synchronizer, then a falling-edge detect in IDLE.
  - START: wait BAUD/2 cycles, resample. If high, return to IDLE (glitch rejected).
  - DATA: 8 samples spaced BAUD.
  - STOP: one sample at BAUD. If high, push the byte; if low, drop it (framing error) and return to IDLE only once the line is high.
  - Push to a full RX FIFO drops the byte and sets rx_overrun.
  - Push and pop in the same cycle on a full FIFO succeeds (no overrun).
- irq_rx = rx_irq_en & rx_valid, registered; one cycle after the condition changes.
- A BAUD write mid-frame takes effect at the next bit boundary.
- Reset mid-frame aborts immediately: tx_pin=1 asynchronously.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - Frames are 8E1. TX inserts an even-parity bit between DATA and STOP.
  - RX samples and checks parity. A mismatch drops the byte and sets STATUS bit5 parity_err (sticky, clear-on-read).
- Undefined: 8N1 only; STATUS bit5 reads 0.

Decomposition:
- Package uart_pkg holds:
  - register offsets (REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_BAUD=2'd3);
  - STATUS bit indices;
  - TX/RX state encodings;
  - BAUD_MIN=16'd4.
- Sub-module uart_fifo (parameter DEPTH, 8-bit):
  - ports push/pop/din/dout/full/empty;
  - show-ahead dout;
  - pointer plus count; instantiated twice.

Test Plan:
- Reset values: reset, read all 4 regs -> DATA=0, STATUS=0x04, CTRL=0, BAUD=434; tx_pin=1; irq_rx=0.
- TX frame: BAUD=4, write DATA=0xA5 -> tx_pin low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; tx_busy=1 during the frame.
- RX loopback with IRQ: BAUD=4, CTRL=1, tx_pin tied to rx_pin, write 0x3C -> rx_valid=1 and irq_rx=1 after the frame; DATA read returns 0x3C; irq_rx drops 2 cycles after ren.
- Overrun: BAUD=4, drive 17 RX frames without reading -> STATUS bit3=1, first 16 bytes 0x00..0x0F intact; second STATUS read shows bit3=0.
- Glitch/framing: a 1-cycle low pulse on rx_pin -> no push. A frame with stop bit low -> no push, rx_valid stays 0.
- TX full: write 17 bytes while BAUD=434 -> tx_full=1 after 16 pending (the first byte leaves the FIFO immediately, so the 17th is accepted). An 18th write is dropped; 17 frames are transmitted.
